jtag_tap_multi: RTL and testbench

Parametrised IEEE 1149.1 TAP with IDCODE, BYPASS, one user-opcode register and N_CHAN independent user data channels, each with its own capture input, update output and update strobe. It is the multi-channel successor to the single-channel user-data TAP. It sits at the chip debug port, between the external JTAG pins and on-chip debug or user logic, entirely in the tck domain.

---
 rtl/jtag_tap_multi.sv | 184 ++++++++++++++++++
 tb/tb_jtag_tap_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS, a user opcode register and
// N_CHAN independent user data channels, all clocked by tck.
module jtag_tap_multi #(
  parameter int              IR_LEN       = 4,
  parameter logic [3:0]      ID_PARTVER   = 4'h1,
  parameter logic [15:0]     ID_PARTNUM   = 16'hBEEF,
  parameter logic [10:0]     ID_MANF      = 11'h035,
  parameter int              USERDATA_LEN = 32,
  parameter int              USEROP_LEN   = 8,
  parameter int              N_CHAN       = 2
) (
  input  logic                           tck,
  input  logic                           trst,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  input  logic [N_CHAN*USERDATA_LEN-1:0] userData_in,
  output logic [N_CHAN*USERDATA_LEN-1:0] userData_out,
  output logic [N_CHAN-1:0]              userData_valid,
  output logic [USEROP_LEN-1:0]          userOp,
  output logic                           userOp_ready
);

  localparam int DR_W = (USERDATA_LEN > 32 && USERDATA_LEN >= USEROP_LEN) ? USERDATA_LEN :
                        (USEROP_LEN > 32) ? USEROP_LEN : 32;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_USEROP = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] IR_USER0  = IR_LEN'(4);
  localparam logic [IR_LEN-1:0] IR_USERN  = IR_LEN'(4 + N_CHAN);
  localparam logic [31:0]       IDCODE_VAL = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_e;

  state_e state_q, state_d;

  logic [IR_LEN-1:0]              ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [DR_W-1:0]                dr_q, dr_d;
  logic [N_CHAN*USERDATA_LEN-1:0] ud_q, ud_d;
  logic [N_CHAN-1:0]              udv_q, udv_d;
  logic [USEROP_LEN-1:0]          op_q, op_d;
  logic                           opr_q, opr_d;
  logic                           tdo_q, tdo_d;

  logic in_tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
  logic sel_idcode, sel_userop, sel_user;
  logic [IR_LEN-1:0] chan;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    in_tlr = (state_q == TLR);
    cap_dr = (state_q == CAP_DR);
    sh_dr  = (state_q == SH_DR);
    upd_dr = (state_q == UPD_DR);
    cap_ir = (state_q == CAP_IR);
    sh_ir  = (state_q == SH_IR);
    upd_ir = (state_q == UPD_IR);
  end

  // Unlisted opcodes (including all-ones) fall through to the 1-bit bypass path.
  always_comb begin
    sel_idcode = (ir_q == IR_IDCODE);
    sel_userop = (ir_q == IR_USEROP);
    sel_user   = (ir_q >= IR_USER0) && (ir_q < IR_USERN);
    chan       = ir_q - IR_USER0;
  end

  always_comb begin
    ir_sh_d = ir_sh_q;
    ir_d    = ir_q;
    if (cap_ir)     ir_sh_d = IR_LEN'(1);
    else if (sh_ir) ir_sh_d = {tdi, ir_sh_q[IR_LEN-1:1]};
    if (in_tlr)      ir_d = IR_IDCODE;
    else if (upd_ir) ir_d = ir_sh_q;
  end

  // tdi always enters at the MSB of whichever register is selected, so the
  // shared shift register's upper bits stay zero for shorter registers.
  always_comb begin
    dr_d  = dr_q;
    ud_d  = ud_q;
    op_d  = op_q;
    udv_d = '0;
    opr_d = 1'b0;
    if (cap_dr) begin
      dr_d = '0;
      if (sel_idcode) begin
        dr_d[31:0] = IDCODE_VAL;
      end else if (sel_userop) begin
        dr_d[USEROP_LEN-1:0] = op_q;
      end else if (sel_user) begin
        for (int k = 0; k < N_CHAN; k++) begin
          if (chan == IR_LEN'(k)) dr_d[USERDATA_LEN-1:0] = userData_in[k*USERDATA_LEN +: USERDATA_LEN];
        end
      end
    end else if (sh_dr) begin
      dr_d = dr_q >> 1;
      if (sel_idcode)      dr_d[31] = tdi;
      else if (sel_userop) dr_d[USEROP_LEN-1] = tdi;
      else if (sel_user)   dr_d[USERDATA_LEN-1] = tdi;
      else                 dr_d[0] = tdi;
    end else if (upd_dr) begin
      if (sel_userop) begin
        op_d  = dr_q[USEROP_LEN-1:0];
        opr_d = 1'b1;
      end else if (sel_user) begin
        for (int k = 0; k < N_CHAN; k++) begin
          if (chan == IR_LEN'(k)) begin
            ud_d[k*USERDATA_LEN +: USERDATA_LEN] = dr_q[USERDATA_LEN-1:0];
            udv_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_q    <= IR_IDCODE;
      ir_sh_q <= '0;
      dr_q    <= '0;
      ud_q    <= '0;
      udv_q   <= '0;
      op_q    <= '0;
      opr_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      ir_sh_q <= ir_sh_d;
      dr_q    <= dr_d;
      ud_q    <= ud_d;
      udv_q   <= udv_d;
      op_q    <= op_d;
      opr_q   <= opr_d;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (sh_dr)      tdo_d = dr_q[0];
    else if (sh_ir) tdo_d = ir_sh_q[0];
  end

  // tdo launches on the falling edge so the host can sample it on the next rising edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign tdo            = tdo_q;
  assign userData_out   = ud_q;
  assign userData_valid = udv_q;
  assign userOp         = op_q;
  assign userOp_ready   = opr_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Scoreboard bench for jtag_tap_multi: stimulus queues expected tdo words and
// update strobes, a monitor compares them as the DUT produces them.
module tb_jtag_tap_multi;
  localparam int IR_LEN = 4;
  localparam int UDL    = 32;
  localparam int UOL    = 8;
  localparam int NCH    = 2;
  localparam logic [63:0] IDCODE = 64'h1BEEF06B;

  logic               tck = 1'b0;
  logic               trst = 1'b0;
  logic               tms = 1'b1;
  logic               tdi = 1'b0;
  logic               tdo;
  logic [NCH*UDL-1:0] ud_in;
  logic [NCH*UDL-1:0] ud_out;
  logic [NCH-1:0]     ud_vld;
  logic [UOL-1:0]     op;
  logic               op_rdy;
  logic               tdo_vld = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    int          len;
    logic [63:0] val;
  } word_t;

  typedef struct {
    string              name;
    logic [NCH-1:0]     vld;
    logic               rdy;
    logic [NCH*UDL-1:0] ud;
    logic [UOL-1:0]     op;
  } strb_t;

  word_t       wq[$];
  strb_t       sq[$];
  logic [63:0] acc;
  int          cnt;

  jtag_tap_multi #(
    .IR_LEN(IR_LEN), .ID_PARTVER(4'h1), .ID_PARTNUM(16'hBEEF), .ID_MANF(11'h035),
    .USERDATA_LEN(UDL), .USEROP_LEN(UOL), .N_CHAN(NCH)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo),
    .userData_in(ud_in), .userData_out(ud_out), .userData_valid(ud_vld),
    .userOp(op), .userOp_ready(op_rdy)
  );

  always #10 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, after tdo has launched and well before the next rising edge.
  initial begin
    strb_t e;
    acc = '0;
    cnt = 0;
    forever begin
      @(negedge tck);
      #3;
      if (tdo_vld) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tdo: got bit %b with no expected word queued", tdo);
        end else begin
          acc = acc | (64'(tdo) << cnt);
          cnt++;
          if (cnt == wq[0].len) begin
            check(wq[0].name, acc, wq[0].val);
            void'(wq.pop_front());
            acc = '0;
            cnt = 0;
          end
        end
      end
      if (ud_vld != '0 || op_rdy) begin
        n_cmp++;
        if (sq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: got vld=%b rdy=%b expected no strobe", ud_vld, op_rdy);
        end else begin
          e = sq.pop_front();
          if ({ud_vld, op_rdy, ud_out, op} !== {e.vld, e.rdy, e.ud, e.op}) begin
            n_bad++;
            $display("FAIL %s: got vld=%b rdy=%b ud=%h op=%h expected vld=%b rdy=%b ud=%h op=%h",
                     e.name, ud_vld, op_rdy, ud_out, op, e.vld, e.rdy, e.ud, e.op);
          end
        end
      end
    end
  end

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic goto_rti();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic shift(input logic [63:0] din, input int n, input int pause_at);
    logic [63:0] sh;
    logic        last;
    sh = din;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) || (pause_at > 0 && i == pause_at - 1);
      tdo_vld = 1'b1;
      tick(last, sh[0]);
      sh = sh >> 1;
      if (last && i != n - 1) begin
        tdo_vld = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end
    end
    tdo_vld = 1'b0;
  endtask

  task automatic scan_ir(input logic [IR_LEN-1:0] v, input string name);
    wq.push_back('{name, IR_LEN, 64'h1});
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift(64'(v), IR_LEN, 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, input int pause_at,
                         input logic [63:0] exp, input string name);
    wq.push_back('{name, n, exp});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift(din, n, pause_at);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic push_strb(input string name, input logic [NCH-1:0] v, input logic r,
                           input logic [NCH*UDL-1:0] u, input logic [UOL-1:0] o);
    sq.push_back('{name, v, r, u, o});
  endtask

  initial begin
    logic [NCH*UDL-1:0] ud2;
    ud2   = {32'hDEADBEEF, 32'h0BADC0DE};
    ud_in = {32'h12345678, 32'hCAFEF00D};
    trst  = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_ud_out", 64'(ud_out), 64'h0);
    check("rst_op", 64'(op), 64'h0);
    check("rst_strobes", 64'({ud_vld, op_rdy}), 64'h0);
    trst = 1'b1;

    goto_rti();
    scan_dr(64'h0, 32, 0, IDCODE, "idcode_after_reset");
    check("op_after_idcode", 64'(op), 64'h0);
    check("ud_after_idcode", 64'(ud_out), 64'h0);

    scan_ir(4'hF, "ir_capture_bypass");
    scan_dr(64'h0A5, 9, 0, 64'h14A, "bypass_delay");

    scan_ir(4'h5, "ir_capture_ch1");
    push_strb("upd_ch1", 2'b10, 1'b0, {32'hDEADBEEF, 32'h0}, 8'h00);
    scan_dr(64'hDEADBEEF, 32, 0, 64'h12345678, "capture_ch1");
    tick(1'b0, 1'b0);
    check("ch0_hold", 64'(ud_out[31:0]), 64'h0);

    scan_ir(4'h4, "ir_capture_ch0");
    push_strb("upd_ch0_paused", 2'b01, 1'b0, ud2, 8'h00);
    scan_dr(64'h0BADC0DE, 32, 12, 64'hCAFEF00D, "capture_ch0_paused");

    scan_ir(4'h2, "ir_capture_userop");
    push_strb("upd_op_3c", 2'b00, 1'b1, ud2, 8'h3C);
    scan_dr(64'h3C, 8, 0, 64'h00, "capture_op_initial");
    push_strb("upd_op_5a", 2'b00, 1'b1, ud2, 8'h5A);
    scan_dr(64'h5A, 8, 0, 64'h3C, "readback_op");
    push_strb("upd_op_zero_shift", 2'b00, 1'b1, ud2, 8'h5A);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    scan_ir(4'h6, "ir_capture_unused");
    scan_dr(64'h3, 2, 0, 64'h2, "unused_code_bypass");

    goto_rti();
    tick(1'b0, 1'b0);
    check("tlr_keeps_op", 64'(op), 64'h5A);
    check("tlr_keeps_ud", 64'(ud_out), 64'(ud2));
    scan_dr(64'h0, 32, 0, IDCODE, "idcode_after_tlr");

    scan_ir(4'h4, "ir_capture_ch0_again");
    wq.push_back('{"partial_ch0", 10, 64'h00D});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tdo_vld = 1'b1;
    repeat (10) tick(1'b0, 1'b1);
    tdo_vld = 1'b0;
    trst = 1'b0;
    #2;
    check("trst_ud_cleared", 64'(ud_out), 64'h0);
    check("trst_op_cleared", 64'(op), 64'h0);
    check("trst_tdo", 64'(tdo), 64'h0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    trst = 1'b1;
    tick(1'b0, 1'b0);
    scan_dr(64'h0, 32, 0, IDCODE, "idcode_after_trst");
    check("ud_after_trst_scan", 64'(ud_out), 64'h0);

    repeat (3) tick(1'b1, 1'b0);
    check("words_pending", 64'(wq.size() + cnt), 64'h0);
    check("strobes_pending", 64'(sq.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
